execute_muldiv: RTL
===================

# execute_muldiv

Parametrised iterative multiply/divide unit with HI/LO registers, sitting beside the single-cycle ALU in the execute stage of the Minisys CPU. It runs MIPS mult/multu/div/divu as a multi-cycle operation, holds results in HI/LO, and services mthi/mtlo writes. The pipeline controller uses `busy` to stall mfhi/mflo and any further mul/div issue. Widths are generic, so the same block serves 16- and 32-bit datapath variants.

## Interface
Parameters:
- WIDTH, 32, operand/HI/LO width; must be ≥ 4
- FAST_MUL, 0, when 1 a multiply finishes in one cycle using a combinational product; divide stays iterative

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; clears all state
- start  in  1  issue md_op with opa/opb; accepted only when busy=0
- md_op  in  2  00 mult, 01 multu, 10 div, 11 divu
- opa  in  WIDTH  rs value (multiplicand / dividend)
- opb  in  WIDTH  rt value (multiplier / divisor)
- flush  in  1  synchronous abort of the in-flight operation
- mthi  in  1  write wdata to HI
- mtlo  in  1  write wdata to LO
- wdata  in  WIDTH  mthi/mtlo data
- busy  out  1  operation in flight; HI/LO not valid
- done  out  1  one-cycle pulse in the cycle after HI/LO are updated by an operation
- hi  out  WIDTH  HI register (product upper half / remainder)
- lo  out  WIDTH  LO register (product lower half / quotient)

## Operation
- Reset values: busy=0, done=0, hi=0, lo=0, FSM in IDLE, iteration counter 0.
- FSM states:
  - IDLE: on start, latch operand magnitudes and the result-sign flags, then go to RUN. For a multiply with FAST_MUL=1, go straight to FIX instead.
  - RUN: one radix-2 step per cycle for exactly WIDTH cycles, then go to FIX. Multiply is shift-add into a 2·WIDTH accumulator. Divide is restoring: shift the remainder, subtract the divisor, keep the result if it is non-negative.
  - FIX: apply signs, write HI/LO, go to IDLE, and assert done in the following cycle.
- Signed ops (mult, div) work on absolute values.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ; remainder takes the dividend's sign.
  - Absolute value of the most negative number is handled in WIDTH+1 bits, with no truncation.
- Divide by zero: lo = all ones, hi = opa unchanged (signed and unsigned). Fixed latency is kept.
- Signed overflow (MIN / −1): lo = MIN, hi = 0, no exception.
- mthi/mtlo while busy=0 write on the next edge; mthi and mtlo together write both registers.
- start, mthi or mtlo while busy=1 is ignored; the pipeline must stall instead.
- start together with mthi/mtlo in IDLE: start wins, the writes are dropped.
- flush while busy: return to IDLE on the next edge, HI/LO unchanged, no done. flush in IDLE has no effect.
- Reset mid-operation: immediate return to reset values.

## Timing
- start sampled high at edge T:
  - busy=1 from after edge T through edge T+WIDTH+1.
  - HI/LO updated at edge T+WIDTH+1.
  - done=1 and busy=0 in the cycle after edge T+WIDTH+1.
- FAST_MUL multiply: busy high for one cycle; HI/LO updated at edge T+1; done after edge T+1.
- A new start is legal in the same cycle as done (back-to-back issue, one idle-free turnaround).
- mthi/mtlo visible on hi/lo one cycle after the write cycle.
- hi/lo are registered outputs; busy and done come directly from registers.

## Test plan
- WIDTH=32, mult opa=FFFFFFFD (−3), opb=5 → hi=FFFFFFFF, lo=FFFFFFF1; done exactly 34 cycles after start; busy high for 33 cycles.
- multu FFFFFFFF×FFFFFFFF → hi=FFFFFFFE, lo=00000001. Repeat with FAST_MUL=1 → same result, done 2 cycles after start.
- div −7/2 → lo=FFFFFFFD, hi=FFFFFFFF. divu 7/0 → lo=FFFFFFFF, hi=00000007. div 80000000/FFFFFFFF → lo=80000000, hi=0.
- Divide running, flush 10 cycles after start → busy low on the next cycle; no done; hi/lo keep their previous values. start asserted while busy → ignored; the result matches the first operation only.
- mthi wdata=12345678 with mtlo low → hi=12345678 next cycle, lo unchanged. mthi+mtlo+start in the same idle cycle → only the operation executes.
- reset asserted asynchronously mid-divide → busy, done, hi, lo all 0 immediately. After release, a fresh divu 100/7 → lo=0000000E, hi=00000002.

Source files
------------

// File: rtl/execute_muldiv.sv
// execute_muldiv: iterative MIPS mult/multu/div/divu unit with HI/LO registers and mthi/mtlo writes.
// Latency: start sampled at edge T -> HI/LO written at edge T+WIDTH+1, done pulses the following cycle
//          (FAST_MUL multiply: HI/LO at edge T+1). Backpressure: busy high while in flight; start/mthi/mtlo ignored.
//
// Ports: clock / reset (async, active-low) | start, md_op, opa, opb issue an operation | flush aborts it |
//        mthi, mtlo, wdata write HI/LO when idle | busy, done status | hi, lo registered results.
module execute_muldiv #(
    parameter int WIDTH    = 32,
    parameter bit FAST_MUL = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       md_op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             flush,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    // Shared datapath register: {upper, lower} product for multiply,
    // {remainder, dividend/quotient} for divide.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;      // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   raw_a;     // untouched dividend for the divide-by-zero result
    logic               is_div;
    logic               neg_res;   // negate product / quotient
    logic               neg_rem;   // negate remainder (dividend was negative)
    logic               div_zero;

    // Operand conditioning. The magnitude of the most negative value is
    // 2^(WIDTH-1), which is representable as an unsigned WIDTH-bit number,
    // so the two's-complement negate below loses nothing.
    logic             op_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    always_comb begin
        op_signed = ~md_op[0];
        a_neg     = op_signed & opa[WIDTH-1];
        b_neg     = op_signed & opb[WIDTH-1];
        mag_a     = a_neg ? -opa : opa;
        mag_b     = b_neg ? -opb : opb;
    end

    // One radix-2 step of either algorithm.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [WIDTH-1:0]   div_rem;
    logic [2*WIDTH-1:0] step_next;

    always_comb begin
        // Shift-add: add multiplicand into the upper half when the multiplier
        // LSB is set, then shift the whole accumulator right with the carry.
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        // Restoring divide: {rem, next dividend bit} minus divisor; keep if non-negative.
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_ge    = div_shift >= {1'b0, opnd};
        div_diff  = div_shift - {1'b0, opnd};
        div_rem   = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
        step_next = is_div ? {div_rem, acc[WIDTH-2:0], div_ge}
                           : {mul_sum, acc[WIDTH-1:1]};
    end

    // When the subtraction is kept its result is below the divisor, so the top bit is always zero.
    logic unused_diff_msb;
    assign unused_diff_msb = div_diff[WIDTH];

    // Sign fix-up and special cases.
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    always_comb begin
        acc_hi = acc[2*WIDTH-1:WIDTH];
        acc_lo = acc[WIDTH-1:0];
        prod   = neg_res ? -acc : acc;
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (is_div) begin
            if (div_zero) begin
                fix_hi = raw_a;
                fix_lo = '1;
            end else begin
                // MIN / -1 needs no special case: magnitude quotient is
                // 2^(WIDTH-1) with equal signs, which reads back as MIN.
                fix_hi = neg_rem ? -acc_hi : acc_hi;
                fix_lo = neg_res ? -acc_lo : acc_lo;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            raw_a    <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        // start takes priority; a simultaneous mthi/mtlo is dropped
                        is_div   <= md_op[1];
                        neg_res  <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        div_zero <= (opb == '0);
                        raw_a    <= opa;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        if (md_op[1]) begin
                            opnd  <= mag_b;
                            acc   <= {{WIDTH{1'b0}}, mag_a};
                            state <= S_RUN;
                        end else begin
                            opnd <= mag_a;
                            if (FAST_MUL) begin
                                acc   <= {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
                                state <= S_FIX;
                            end else begin
                                acc   <= {{WIDTH{1'b0}}, mag_b};
                                state <= S_RUN;
                            end
                        end
                    end else begin
                        if (mthi) hi <= wdata;
                        if (mtlo) lo <= wdata;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        acc <= step_next;
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1)) state <= S_FIX;
                    end
                end
                S_FIX: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    if (!flush) begin
                        hi   <= fix_hi;
                        lo   <= fix_lo;
                        done <= 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
